// File: rtl/disp_scan_ctrl_amisha_if.sv
// Frame-load handshake bundle for the 4-digit scan controller.
// Carries valid/ready plus the four segment patterns and enable mask.
interface disp_scan_ctrl_amisha_if;
  logic       load_valid_amisha;
  logic       load_ready_amisha;
  logic [7:0] in0_amisha;
  logic [7:0] in1_amisha;
  logic [7:0] in2_amisha;
  logic [7:0] in3_amisha;
  logic [3:0] en_amisha;

  modport master (
    output load_valid_amisha,
    output in0_amisha,
    output in1_amisha,
    output in2_amisha,
    output in3_amisha,
    output en_amisha,
    input  load_ready_amisha
  );

  modport slave (
    input  load_valid_amisha,
    input  in0_amisha,
    input  in1_amisha,
    input  in2_amisha,
    input  in3_amisha,
    input  en_amisha,
    output load_ready_amisha
  );
endinterface

// File: rtl/disp_scan_ctrl_amisha.sv
// Tear-free 4-digit 7-segment scan controller with double-buffered frames.
// Optional PWM brightness via macro DISP_BRIGHTNESS_EN.
module disp_scan_ctrl_amisha #(
  parameter int DWELL_CYCLES = 50000
) (
  input  logic       clk_amisha,
  input  logic       reset_n_amisha,
`ifdef DISP_BRIGHTNESS_EN
  input  logic [1:0] bright_amisha,
`endif
  disp_scan_ctrl_amisha_if.slave ld,
  output logic [3:0] an_amisha,
  output logic [7:0] sseg_amisha,
  output logic       frame_amisha
);

  localparam int CW = $clog2(DWELL_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DWELL_CYCLES - 1);

  typedef enum logic {SCAN, PEND} state_t;

  state_t      state_q;
  state_t      state_d;
  logic        run_q;
  logic [CW-1:0] slot_q;
  logic [1:0]  dig_q;
  logic [7:0]  act_q [4];
  logic [7:0]  pend_q [4];
  logic [3:0]  act_en_q;
  logic [3:0]  pend_en_q;
  logic [7:0]  in_pat [4];

  logic ready;
  logic xfer;
  logic cap_act;
  logic cap_pend;
  logic promote;
  logic lim_ok;
  logic lit;

  assign in_pat[0] = ld.in0_amisha;
  assign in_pat[1] = ld.in1_amisha;
  assign in_pat[2] = ld.in2_amisha;
  assign in_pat[3] = ld.in3_amisha;

  assign frame_amisha = (dig_q == 2'd3) && (slot_q == LAST);
  // run_q keeps ready low while reset is held
  assign ready = run_q && (state_q == SCAN);
  assign ld.load_ready_amisha = ready;
  assign xfer = ld.load_valid_amisha && ready;

  always_ff @(posedge clk_amisha or negedge reset_n_amisha) begin
    if (!reset_n_amisha) begin
      state_q <= SCAN;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    cap_act  = 1'b0;
    cap_pend = 1'b0;
    promote  = 1'b0;
    unique case (state_q)
      SCAN: begin
        if (xfer) begin
          if (frame_amisha) begin
            cap_act = 1'b1;
          end else begin
            cap_pend = 1'b1;
            state_d  = PEND;
          end
        end
      end
      PEND: begin
        if (frame_amisha) begin
          promote = 1'b1;
          state_d = SCAN;
        end
      end
      default: state_d = SCAN;
    endcase
  end

  always_ff @(posedge clk_amisha or negedge reset_n_amisha) begin
    if (!reset_n_amisha) begin
      slot_q <= '0;
      dig_q  <= 2'd0;
    end else if (slot_q == LAST) begin
      slot_q <= '0;
      dig_q  <= dig_q + 2'd1;
    end else begin
      slot_q <= slot_q + CW'(1);
    end
  end

  always_ff @(posedge clk_amisha or negedge reset_n_amisha) begin
    if (!reset_n_amisha) begin
      for (int i = 0; i < 4; i++) begin
        act_q[i]  <= 8'hFF;
        pend_q[i] <= 8'hFF;
      end
      act_en_q  <= 4'h0;
      pend_en_q <= 4'h0;
    end else begin
      if (cap_act) begin
        for (int i = 0; i < 4; i++) act_q[i] <= in_pat[i];
        act_en_q <= ld.en_amisha;
      end else if (promote) begin
        for (int i = 0; i < 4; i++) act_q[i] <= pend_q[i];
        act_en_q <= pend_en_q;
      end
      if (cap_pend) begin
        for (int i = 0; i < 4; i++) pend_q[i] <= in_pat[i];
        pend_en_q <= ld.en_amisha;
      end
    end
  end

`ifdef DISP_BRIGHTNESS_EN
  logic [CW+2:0] on_prod;
  logic [CW+2:0] on_lim;

  always_comb begin
    on_prod = (CW+3)'({1'b0, bright_amisha} + 3'd1)
            * (CW+3)'(DWELL_CYCLES);
    on_lim  = on_prod >> 2;
    lim_ok  = ({3'b000, slot_q} < on_lim);
  end
`else
  assign lim_ok = 1'b1;
`endif

  // first two slot cycles stay dark to hide anode switching ghosts
  assign lit = act_en_q[dig_q] && (slot_q >= CW'(2)) && lim_ok;

  always_ff @(posedge clk_amisha or negedge reset_n_amisha) begin
    if (!reset_n_amisha) begin
      an_amisha   <= 4'hF;
      sseg_amisha <= 8'hFF;
    end else if (lit) begin
      an_amisha   <= ~(4'b0001 << dig_q);
      sseg_amisha <= act_q[dig_q];
    end else begin
      an_amisha   <= 4'hF;
      sseg_amisha <= 8'hFF;
    end
  end

endmodule

// File: tb/tb_disp_scan_ctrl_amisha.sv
// Directed bench for disp_scan_ctrl_amisha with a cycle model and
// an expected-output queue matched against the registered display.
module tb_disp_scan_ctrl_amisha;
  localparam int DW = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] bright = 2'd3;
  logic [3:0] an;
  logic [7:0] sseg;
  logic       frame;

  disp_scan_ctrl_amisha_if ld();

  always #5 clk = ~clk;

  disp_scan_ctrl_amisha #(.DWELL_CYCLES(DW)) dut (
    .clk_amisha     (clk),
    .reset_n_amisha (rst_n),
`ifdef DISP_BRIGHTNESS_EN
    .bright_amisha  (bright),
`endif
    .ld             (ld.slave),
    .an_amisha      (an),
    .sseg_amisha    (sseg),
    .frame_amisha   (frame)
  );

  typedef struct packed {
    logic [3:0] an;
    logic [7:0] sseg;
  } out_t;

  out_t exp_q[$];

  int         m_slot;
  int         m_dig;
  bit         m_pend;
  bit         m_run;
  logic [7:0] m_act [4];
  logic [7:0] m_pnd [4];
  logic [3:0] m_ena;
  logic [3:0] m_enp;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
  endtask

  task automatic m_reset();
    m_slot = 0;
    m_dig  = 0;
    m_pend = 1'b0;
    m_run  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      m_act[i] = 8'hFF;
      m_pnd[i] = 8'hFF;
    end
    m_ena = 4'h0;
    m_enp = 4'h0;
    exp_q.delete();
  endtask

  function automatic out_t m_out();
    out_t o;
    int   on;
    bit   lit;
    on = DW;
`ifdef DISP_BRIGHTNESS_EN
    on = ((int'(bright) + 1) * DW) / 4;
`endif
    lit = m_ena[m_dig] && (m_slot >= 2) && (m_slot < on);
    o.an   = lit ? ~(4'b0001 << m_dig) : 4'hF;
    o.sseg = lit ? m_act[m_dig] : 8'hFF;
    return o;
  endfunction

  task automatic tick();
    bit         fr;
    bit         rdy;
    bit         xfer;
    logic [7:0] ip [4];
    logic [3:0] ie;
    out_t       e;
    fr  = (m_dig == 3) && (m_slot == DW - 1);
    rdy = m_run && !m_pend;
    chk("frame", frame, fr);
    chk("ready", ld.load_ready_amisha, rdy);
    exp_q.push_back(m_out());
    xfer  = ld.load_valid_amisha && rdy;
    ip[0] = ld.in0_amisha;
    ip[1] = ld.in1_amisha;
    ip[2] = ld.in2_amisha;
    ip[3] = ld.in3_amisha;
    ie    = ld.en_amisha;
    @(posedge clk);
    if (!m_pend) begin
      if (xfer && fr) begin
        for (int i = 0; i < 4; i++) m_act[i] = ip[i];
        m_ena = ie;
      end else if (xfer) begin
        for (int i = 0; i < 4; i++) m_pnd[i] = ip[i];
        m_enp  = ie;
        m_pend = 1'b1;
      end
    end else if (fr) begin
      for (int i = 0; i < 4; i++) m_act[i] = m_pnd[i];
      m_ena  = m_enp;
      m_pend = 1'b0;
    end
    m_run = 1'b1;
    if (m_slot == DW - 1) begin
      m_slot = 0;
      m_dig  = (m_dig + 1) % 4;
    end else begin
      m_slot++;
    end
    @(negedge clk);
    e = exp_q.pop_front();
    chk("an", an, e.an);
    chk("sseg", sseg, e.sseg);
  endtask

  task automatic load(input logic [7:0] p0, input logic [7:0] p1,
                      input logic [7:0] p2, input logic [7:0] p3,
                      input logic [3:0] en);
    ld.in0_amisha = p0;
    ld.in1_amisha = p1;
    ld.in2_amisha = p2;
    ld.in3_amisha = p3;
    ld.en_amisha  = en;
    ld.load_valid_amisha = 1'b1;
  endtask

  task automatic idle();
    ld.load_valid_amisha = 1'b0;
  endtask

  task automatic wait_frame();
    for (int i = 0; i < 40 && !frame; i++) tick();
    chk("frame_wait", frame, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    idle();
    load(8'h00, 8'h00, 8'h00, 8'h00, 4'h0);
    idle();
    m_reset();
    #12;
    chk("rst_an", an, 4'hF);
    chk("rst_sseg", sseg, 8'hFF);
    chk("rst_frame", frame, 1'b0);
    chk("rst_ready", ld.load_ready_amisha, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) tick();

    // mid-frame load lands in pending, shown only after the frame pulse
    load(8'hC0, 8'hF9, 8'hA4, 8'hB0, 4'hF);
    tick();
    idle();
    chk("ready_pend", ld.load_ready_amisha, 1'b0);
    wait_frame();
    tick();
    repeat (3) tick();
    chk("d0_an", an, 4'hE);
    chk("d0_sseg", sseg, 8'hC0);
    repeat (40) tick();

    // sparse enable mask
    load(8'h92, 8'h82, 8'hF8, 8'h80, 4'b0101);
    tick();
    idle();
    wait_frame();
    tick();
    repeat (11) tick();
    chk("d1_off_an", an, 4'hF);
    chk("d1_off_sseg", sseg, 8'hFF);
    repeat (8) tick();
    chk("d2_on_an", an, 4'hB);
    chk("d2_on_sseg", sseg, 8'hF8);

    // load on the frame cycle goes straight to active
    wait_frame();
    load(8'h99, 8'h90, 8'h88, 8'h83, 4'hF);
    tick();
    idle();
    chk("ready_direct", ld.load_ready_amisha, 1'b1);
    repeat (3) tick();
    chk("direct_an", an, 4'hE);
    chk("direct_sseg", sseg, 8'h99);

    // second offer while pending is held off until after the frame
    repeat (4) tick();
    load(8'h88, 8'hC6, 8'hA1, 8'h86, 4'hF);
    tick();
    load(8'h83, 8'h8E, 8'hC2, 8'h89, 4'hF);
    chk("ready_busy", ld.load_ready_amisha, 1'b0);
    wait_frame();
    chk("ready_at_frame", ld.load_ready_amisha, 1'b0);
    tick();
    chk("ready_after", ld.load_ready_amisha, 1'b1);
    tick();
    idle();
    chk("ready_b_pend", ld.load_ready_amisha, 1'b0);
    repeat (2) tick();
    chk("a_shown_sseg", sseg, 8'h88);
    wait_frame();
    tick();
    repeat (3) tick();
    chk("b_shown_sseg", sseg, 8'h83);

    // asynchronous reset while a frame is pending
    load(8'hF9, 8'hF9, 8'hF9, 8'hF9, 4'hF);
    tick();
    idle();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_an", an, 4'hF);
    chk("arst_sseg", sseg, 8'hFF);
    chk("arst_ready", ld.load_ready_amisha, 1'b0);
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("ready_rel", ld.load_ready_amisha, 1'b1);
    wait_frame();
    tick();
    repeat (3) tick();
    chk("blank_an", an, 4'hF);
    chk("blank_sseg", sseg, 8'hFF);

`ifdef DISP_BRIGHTNESS_EN
    load(8'hC0, 8'hF9, 8'hA4, 8'hB0, 4'hF);
    tick();
    idle();
    for (int b = 0; b < 4; b++) begin
      bright = 2'(b);
      repeat (32) tick();
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/disp_scan_ctrl_amisha.md
DISP_SCAN_CTRL_AMISHA -- requirements
Module: disp_scan_ctrl_amisha

Interface
REQ-001 Parameter DWELL_CYCLES, default 50000, clocks per digit slot; legal range 8..2^20.
REQ-002 clk_amisha  input  1  sole clock, all state on rising edge.
REQ-003 reset_n_amisha  input  1  reset, asynchronous, active-low.
REQ-004 load_valid_amisha  input  1  new display frame offered.
REQ-005 load_ready_amisha  output  1  controller can accept a frame.
REQ-006 in0_amisha..in3_amisha  input  8 each  segment patterns, active-low, {dp,g..a}, digit 0 = rightmost.
REQ-007 en_amisha  input  4  per-digit enable mask, captured with the patterns.
REQ-008 bright_amisha  input  2  brightness level 0..3, present only with DISP_BRIGHTNESS_EN.
REQ-009 an_amisha  output  4  anode drive, active-low, at most one bit low.
REQ-010 sseg_amisha  output  8  segment drive, active-low.
REQ-011 frame_amisha  output  1  one-cycle pulse, last cycle of digit-3 slot.

Function
REQ-012 slot_cnt counts 0..DWELL_CYCLES-1 and wraps; on wrap, digit index advances 0->1->2->3->0.
REQ-013 frame_amisha SHALL be 1 exactly when digit index = 3 and slot_cnt = DWELL_CYCLES-1.
REQ-014 Two register banks: active (drives display) and pending (holds an accepted frame not yet shown).
REQ-015 FSM states: SCAN (no pending frame) and PEND (pending frame held).
REQ-016 load_ready_amisha SHALL be 1 in SCAN and 0 in PEND; transfer occurs on valid&ready at a rising edge.
REQ-017 SCAN, transfer with frame_amisha=0: capture in0..in3 and en into pending, go to PEND.
REQ-018 SCAN, transfer with frame_amisha=1: capture directly into active, stay SCAN.
REQ-019 PEND, frame_amisha=1: copy pending to active, go to SCAN; load_valid ignored that cycle.
REQ-020 Active bank SHALL only change at a frame boundary (no tearing mid-frame).
REQ-021 Digit i lit when en[i]=1 (active), slot_cnt >= 2 (ghost guard), and slot_cnt < on-limit.
REQ-022 Lit: an_amisha = one-hot-low bit i, sseg_amisha = active pattern i; unlit: an_amisha=4'hF, sseg_amisha=8'hFF.
REQ-023 an_amisha/sseg_amisha registered; one cycle latency from slot_cnt/digit index/active bank.
REQ-024 on-limit = DWELL_CYCLES (full slot) when brightness feature absent.
REQ-025 No combinational path from any input to any output except none; load_ready_amisha is a function of state only.

Reset
REQ-026 reset_n_amisha low asynchronously forces: slot_cnt=0, digit index=0, state SCAN, active/pending patterns 8'hFF, enables 4'h0.
REQ-027 During reset: an_amisha=4'hF, sseg_amisha=8'hFF, frame_amisha=0, load_ready_amisha=0.
REQ-028 First rising edge after deassertion: load_ready_amisha=1, counting starts from 0.
REQ-029 Reset mid-frame discards any pending frame; display blank until next accepted frame reaches active.

Configuration
REQ-030 Macro DISP_BRIGHTNESS_EN defined: bright_amisha port exists; on-limit = ((bright+1)*DWELL_CYCLES)/4, integer division; bright sampled live each cycle.
REQ-031 Macro undefined: bright_amisha port absent, on-limit = DWELL_CYCLES, no PWM logic.

Verification (DWELL_CYCLES=8)
REQ-032 Reset, load in0..3=C0,F9,A4,B0, en=F mid-frame -> ready drops, active unchanged until frame pulse, then an cycles E,D,B,7 with sseg C0,F9,A4,B0, anodes high for slot_cnt 0..1.
REQ-033 en=4'b0101 -> digits 1,3 slots show an=F, sseg=FF; digits 0,2 lit.
REQ-034 load_valid held high through frame_amisha=1 in SCAN -> data goes directly to active, ready stays 1, new pattern appears in next digit-0 slot.
REQ-035 Second load offered in PEND -> ready=0, not accepted; accepted the cycle after frame pulse.
REQ-036 DISP_BRIGHTNESS_EN, bright=0 -> each digit lit for slot_cnt 2..1 only i.e. never lit; bright=1 -> lit slot_cnt 2..3; bright=3 -> lit 2..7.
REQ-037 reset_n_amisha pulsed low in PEND -> outputs blank immediately, pending discarded, ready=1 after release.
